ir_fetch_sequencer: RTL and testbench

Downstream consumer of the IR regfile that the instruction loader fills. Starting from a programme counter, it reads one instruction word (opcode plus three operand bytes P0, P1, P2) from four consecutive regfile addresses. It presents the word to the execute stage over a valid/ready handshake, then advances the PC sequentially or to a branch target. It stalls regfile reads while the loader owns the regfile.

---
 rtl/ir_fetch_sequencer.sv | 165 ++++++++++++++++
 tb/tb_ir_fetch_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ir_fetch_sequencer.sv
// ir_fetch_sequencer: reads a four-byte instruction word (opcode, P0, P1, P2)
// from the IR regfile at the current PC, presents it over a valid/ready
// handshake, then advances the PC sequentially or to a branch target.
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   start, start_addr              begin fetching at start_addr (IDLE only)
//   halt                           stop after the current word is accepted
//   ir_busy                        loader owns the regfile; suppress reads
//   ir_regfile_ren/addr/data       regfile read port (data one cycle after ren)
//   ir_out, p0_out, p1_out, p2_out fetched opcode and operands
//   ir_valid, ir_ready             word handshake to the execute stage
//   branch_en, branch_addr         next-PC select, sampled on handshake
//   pc                             address of the word being fetched/presented
//   busy                           high in every state except IDLE
module ir_fetch_sequencer #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] start_addr,
   input  logic                  halt,
   input  logic                  ir_busy,
   output logic                  ir_regfile_ren,
   output logic [ADDR_WIDTH-1:0] ir_regfile_addr,
   input  logic [DATA_WIDTH-1:0] ir_regfile_data,
   output logic [DATA_WIDTH-1:0] ir_out,
   output logic [DATA_WIDTH-1:0] p0_out,
   output logic [DATA_WIDTH-1:0] p1_out,
   output logic [DATA_WIDTH-1:0] p2_out,
   output logic                  ir_valid,
   input  logic                  ir_ready,
   input  logic                  branch_en,
   input  logic [ADDR_WIDTH-1:0] branch_addr,
   output logic [ADDR_WIDTH-1:0] pc,
   output logic                  busy
);

   localparam int unsigned SLOT_W   = 2;
   localparam int unsigned WORD_LEN = 4;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_WAIT  = 2'd2,
      S_ISSUE = 2'd3
   } state_t;

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_pc;
   logic [SLOT_W-1:0]     r_slot;
   logic                  r_halt_pend;
   logic                  r_rd_pend;
   logic [SLOT_W-1:0]     r_rd_slot;
   logic [DATA_WIDTH-1:0] r_ir;
   logic [DATA_WIDTH-1:0] r_p0;
   logic [DATA_WIDTH-1:0] r_p1;
   logic [DATA_WIDTH-1:0] r_p2;

   state_t                w_state_nxt;
   logic [ADDR_WIDTH-1:0] w_pc_nxt;
   logic [SLOT_W-1:0]     w_slot_nxt;
   logic                  w_halt_nxt;
   logic                  w_ren;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic                  w_halt_eff;

   // State and control registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_pc        <= '0;
         r_slot      <= '0;
         r_halt_pend <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_pc        <= w_pc_nxt;
         r_slot      <= w_slot_nxt;
         r_halt_pend <= w_halt_nxt;
      end
   end

   // Next-state, PC/slot update and combinational read port
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_slot_nxt  = r_slot;
      w_halt_nxt  = r_halt_pend | halt;
      w_ren       = 1'b0;
      w_addr      = r_pc;
      // A halt arriving with the handshake still ends on that handshake
      w_halt_eff  = r_halt_pend | halt;

      case (r_state)
         S_IDLE: begin
            w_halt_nxt = 1'b0;
            if (start) begin
               w_pc_nxt    = start_addr;
               w_slot_nxt  = '0;
               w_state_nxt = S_FETCH;
            end
         end
         S_FETCH: begin
            if (!ir_busy) begin
               w_ren      = 1'b1;
               w_addr     = r_pc + ADDR_WIDTH'(r_slot);
               w_slot_nxt = r_slot + SLOT_W'(1);
               if (r_slot == SLOT_W'(WORD_LEN - 1)) begin
                  w_state_nxt = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            w_state_nxt = S_ISSUE;
         end
         S_ISSUE: begin
            if (ir_ready) begin
               w_pc_nxt    = branch_en ? branch_addr : r_pc + ADDR_WIDTH'(WORD_LEN);
               w_slot_nxt  = '0;
               w_halt_nxt  = 1'b0;
               w_state_nxt = w_halt_eff ? S_IDLE : S_FETCH;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Capture of read data one cycle after each issued read
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_pend <= 1'b0;
         r_rd_slot <= '0;
         r_ir      <= '0;
         r_p0      <= '0;
         r_p1      <= '0;
         r_p2      <= '0;
      end else begin
         r_rd_pend <= w_ren;
         r_rd_slot <= r_slot;
         if (r_rd_pend) begin
            case (r_rd_slot)
               2'd0:    r_ir <= ir_regfile_data;
               2'd1:    r_p0 <= ir_regfile_data;
               2'd2:    r_p1 <= ir_regfile_data;
               default: r_p2 <= ir_regfile_data;
            endcase
         end
      end
   end

   assign ir_regfile_ren  = w_ren;
   assign ir_regfile_addr = w_addr;
   assign ir_out          = r_ir;
   assign p0_out          = r_p0;
   assign p1_out          = r_p1;
   assign p2_out          = r_p2;
   assign ir_valid        = (r_state == S_ISSUE);
   assign busy            = (r_state != S_IDLE);
   assign pc              = r_pc;

endmodule

// File: tb/tb_ir_fetch_sequencer.sv
// Testbench for ir_fetch_sequencer: directed scenarios followed by random
// stimulus, every cycle compared against a transaction-level reference model.
module tb_ir_fetch_sequencer;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] start_addr;
   logic       halt;
   logic       ir_busy;
   logic       ren;
   logic [7:0] addr;
   logic [7:0] rdata;
   logic [7:0] ir_out, p0_out, p1_out, p2_out;
   logic       ir_valid;
   logic       ir_ready;
   logic       branch_en;
   logic [7:0] branch_addr;
   logic [7:0] pc;
   logic       busy;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] mem [256];

   ir_fetch_sequencer #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .start           (start),
      .start_addr      (start_addr),
      .halt            (halt),
      .ir_busy         (ir_busy),
      .ir_regfile_ren  (ren),
      .ir_regfile_addr (addr),
      .ir_regfile_data (rdata),
      .ir_out          (ir_out),
      .p0_out          (p0_out),
      .p1_out          (p1_out),
      .p2_out          (p2_out),
      .ir_valid        (ir_valid),
      .ir_ready        (ir_ready),
      .branch_en       (branch_en),
      .branch_addr     (branch_addr),
      .pc              (pc),
      .busy            (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Regfile: synchronous read, data valid the cycle after ren
   always @(posedge clk) begin
      if (ren) rdata <= mem[addr];
   end

   // Reference model: instruction-level view of the sequencer
   bit         m_run;      // an instruction stream is active
   int         m_nread;    // reads issued for the current word (0..4)
   bit         m_gap;      // post-read gap cycle elapsed, word presented
   bit         m_halt;
   logic [7:0] m_pc;
   logic [7:0] m_out [4];
   bit         pend_v;
   int         pend_k;
   logic [7:0] pend_d;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_run = 0; m_nread = 0; m_gap = 0; m_halt = 0; m_pc = 8'h00;
      for (int i = 0; i < 4; i++) m_out[i] = 8'h00;
      pend_v = 0; pend_k = 0; pend_d = 8'h00;
   endtask

   task automatic model_check();
      bit         e_ren;
      logic [7:0] e_addr;
      e_ren  = m_run && (m_nread < 4) && !ir_busy;
      e_addr = e_ren ? 8'(m_pc + 8'(m_nread)) : m_pc;
      check("ren",   ren,      e_ren);
      check("addr",  addr,     e_addr);
      check("valid", ir_valid, m_run && m_gap);
      check("busy",  busy,     m_run);
      check("pc",    pc,       m_pc);
      check("ir",    ir_out,   m_out[0]);
      check("p0",    p0_out,   m_out[1]);
      check("p1",    p1_out,   m_out[2]);
      check("p2",    p2_out,   m_out[3]);
   endtask

   task automatic model_advance();
      bit rd;
      rd = m_run && (m_nread < 4) && !ir_busy;
      if (pend_v) m_out[pend_k] = pend_d;
      pend_v = rd;
      if (rd) begin
         pend_k = m_nread;
         pend_d = mem[8'(m_pc + 8'(m_nread))];
      end
      if (!m_run) begin
         if (start) begin
            m_run = 1; m_pc = start_addr; m_nread = 0; m_gap = 0; m_halt = 0;
         end
      end else begin
         if (halt) m_halt = 1;
         if (m_nread < 4) begin
            if (rd) m_nread++;
         end else if (!m_gap) begin
            m_gap = 1;
         end else if (ir_ready) begin
            m_pc    = branch_en ? branch_addr : 8'(m_pc + 8'd4);
            m_nread = 0;
            m_gap   = 0;
            if (m_halt) m_run = 0;
            m_halt  = 0;
         end
      end
   endtask

   // One clock: check at negedge, advance model on posedge, return at posedge+1
   task automatic step();
      @(negedge clk);
      model_check();
      @(posedge clk);
      model_advance();
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      model_reset();
      check("rst_ren",   ren,      0);
      check("rst_addr",  addr,     0);
      check("rst_ir",    ir_out,   0);
      check("rst_p0",    p0_out,   0);
      check("rst_p1",    p1_out,   0);
      check("rst_p2",    p2_out,   0);
      check("rst_valid", ir_valid, 0);
      check("rst_pc",    pc,       0);
      check("rst_busy",  busy,     0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic drain();
      halt = 1'b1; ir_ready = 1'b1; ir_busy = 1'b0; start = 1'b0; branch_en = 1'b0;
      for (int i = 0; i < 40 && m_run; i++) step();
      halt = 1'b0;
      #2;
      check("drain_idle", busy, 0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; start_addr = 8'h00; halt = 1'b0; ir_busy = 1'b0;
      ir_ready = 1'b0; branch_en = 1'b0; branch_addr = 8'h00; rdata = 8'h00;
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      mem[8'h10] = 8'hA1; mem[8'h11] = 8'hB2; mem[8'h12] = 8'hC3; mem[8'h13] = 8'hD4;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      do_reset();

      // Basic fetch at 0x10, ready high
      start = 1'b1; start_addr = 8'h10; ir_ready = 1'b1;
      step();
      start = 1'b0;
      repeat (5) step();
      #2;
      check("tp1_valid", ir_valid, 1);
      check("tp1_ir", ir_out, 8'hA1);
      check("tp1_p0", p0_out, 8'hB2);
      check("tp1_p1", p1_out, 8'hC3);
      check("tp1_p2", p2_out, 8'hD4);
      step();
      #2;
      check("tp1_next_ren", ren, 1);
      check("tp1_next_addr", addr, 8'h14);
      drain();

      // Address wrap from 0xFE
      start = 1'b1; start_addr = 8'hFE;
      step();
      start = 1'b0;
      repeat (6) step();
      #2;
      check("tp2_pc", pc, 8'h02);
      drain();

      // Three-cycle stall at slot 2
      start = 1'b1; start_addr = 8'h10;
      step();
      start = 1'b0;
      repeat (2) step();
      ir_busy = 1'b1;
      repeat (3) step();
      ir_busy = 1'b0;
      #2;
      check("tp3_late_ren", ren, 1);
      check("tp3_late_addr", addr, 8'h12);
      repeat (3) step();
      #2;
      check("tp3_valid_c9", ir_valid, 1);
      check("tp3_p1", p1_out, 8'hC3);
      check("tp3_p2", p2_out, 8'hD4);
      drain();

      // Back-pressure then branch
      ir_ready = 1'b0;
      start = 1'b1; start_addr = 8'h10;
      step();
      start = 1'b0;
      repeat (10) step();
      branch_en = 1'b1; branch_addr = 8'h40; ir_ready = 1'b1;
      #2;
      check("tp4_valid_held", ir_valid, 1);
      step();
      branch_en = 1'b0;
      #2;
      check("tp4_branch_ren", ren, 1);
      check("tp4_branch_addr", addr, 8'h40);
      drain();

      // Halt during fetch; start while busy is ignored
      start = 1'b1; start_addr = 8'h20;
      step();
      start = 1'b0;
      step();
      halt = 1'b1;
      step();
      halt = 1'b0; start = 1'b1; start_addr = 8'h80;
      step();
      start = 1'b0;
      for (int i = 0; i < 12 && m_run; i++) step();
      #2;
      check("tp5_busy", busy, 0);
      check("tp5_pc", pc, 8'h24);
      repeat (3) step();

      // Reset during WAIT, then clean restart
      start = 1'b1; start_addr = 8'h10;
      step();
      start = 1'b0;
      repeat (4) step();
      do_reset();
      start = 1'b1; start_addr = 8'h10;
      step();
      start = 1'b0;
      repeat (6) step();
      #2;
      check("tp6_p2_retained", p2_out, 8'hD4);
      drain();

      // Random stimulus against the model
      for (int c = 0; c < 3000; c++) begin
         ir_busy     = ($urandom_range(0, 3) == 0);
         ir_ready    = ($urandom_range(0, 2) != 0);
         branch_en   = ($urandom_range(0, 3) == 0);
         branch_addr = 8'($urandom);
         halt        = ($urandom_range(0, 15) == 0);
         start       = ($urandom_range(0, 3) == 0);
         start_addr  = 8'($urandom);
         if ($urandom_range(0, 399) == 0) do_reset();
         else step();
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
